// File: rtl/clint_bus_arbiter.sv
// clint_bus_arbiter: round-robin two-master arbiter sharing the CLINT register port.
// Each transaction runs IDLE (grant) -> ACCESS (one slave strobe) -> RESP (ack to the owner).
module clint_bus_arbiter #(
    parameter int DATA_W        = 32,
    parameter bit RR_RESET_LAST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_m0_req,
    input  logic              i_m0_wen,
    input  logic [DATA_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wrdata,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_rddata,
    input  logic              i_m1_req,
    input  logic              i_m1_wen,
    input  logic [DATA_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wrdata,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_rddata,
    output logic              o_s_wen,
    output logic              o_s_ren,
    output logic [DATA_W-1:0] o_s_addr,
    output logic [DATA_W-1:0] o_s_wrdata,
    input  logic [DATA_W-1:0] i_s_rddata,
    output logic              o_busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic grant, win, owner, lwen, last_grant;
    logic [DATA_W-1:0] laddr, lwdata, m0_rd, m1_rd;
    // m1 wins only when alone or when m0 was served last
    assign win = i_m1_req && (!i_m0_req || !last_grant);
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        grant       = (state == IDLE) && (i_m0_req || i_m1_req);
        state_nx    = grant ? ACCESS : (state == ACCESS) ? RESP : IDLE;
        o_s_wen     = (state == ACCESS) && lwen;
        o_s_ren     = (state == ACCESS) && !lwen;
        o_m0_ack    = (state == RESP) && !owner;
        o_m1_ack    = (state == RESP) && owner;
        o_busy      = state != IDLE;
        o_s_addr    = laddr;
        o_s_wrdata  = lwdata;
        o_m0_rddata = m0_rd;
        o_m1_rddata = m1_rd;
    end
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            owner      <= 1'b0;
            lwen       <= 1'b0;
            laddr      <= '0;
            lwdata     <= '0;
            last_grant <= RR_RESET_LAST;
            m0_rd      <= '0;
            m1_rd      <= '0;
        end else begin
            if (grant) begin
                owner  <= win;
                lwen   <= win ? i_m1_wen : i_m0_wen;
                laddr  <= win ? i_m1_addr : i_m0_addr;
                lwdata <= win ? i_m1_wrdata : i_m0_wrdata;
            end
            if (state == ACCESS) begin
                last_grant <= owner;
                if (!owner) m0_rd <= lwen ? '0 : i_s_rddata;
                if (owner)  m1_rd <= lwen ? '0 : i_s_rddata;
            end
        end
    end
endmodule

// File: tb/tb_clint_bus_arbiter.sv
// tb_clint_bus_arbiter: directed and random checks of the arbiter against a
// transaction-timing model (grant at T, strobe at T+1, ack at T+2, round-robin ties).
module tb_clint_bus_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic m0_req = 0, m0_wen = 0, m1_req = 0, m1_wen = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic m0_ack, m1_ack, s_wen, s_ren, busy;
    logic [31:0] m0_rd, m1_rd, s_addr, s_wdata, s_rdata;

    function automatic logic [31:0] srd(input logic [31:0] a);
        return (a == 32'h2000_BFF8) ? 32'h0000_0123 : {a[15:0], ~a[31:16]};
    endfunction
    assign s_rdata = srd(s_addr);

    clint_bus_arbiter dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_m0_req(m0_req), .i_m0_wen(m0_wen), .i_m0_addr(m0_addr), .i_m0_wrdata(m0_wdata),
        .o_m0_ack(m0_ack), .o_m0_rddata(m0_rd),
        .i_m1_req(m1_req), .i_m1_wen(m1_wen), .i_m1_addr(m1_addr), .i_m1_wrdata(m1_wdata),
        .o_m1_ack(m1_ack), .o_m1_rddata(m1_rd),
        .o_s_wen(s_wen), .o_s_ren(s_ren), .o_s_addr(s_addr), .o_s_wrdata(s_wdata),
        .i_s_rddata(s_rdata), .o_busy(busy)
    );

    int n_assert = 0, n_fail = 0;
    int t = 0, tx_t, tx_owner, last;
    logic tx_wen, mack0, mack1;
    logic [31:0] tx_addr, tx_wdata;
    logic [31:0] exp_rd [2];
    int ack_cyc[$], ack_who[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tx_t = -100; tx_owner = 0; tx_wen = 0; tx_addr = 0; tx_wdata = 0;
        last = 1; exp_rd[0] = 0; exp_rd[1] = 0; mack0 = 0; mack1 = 0;
    endtask

    task automatic check_cycle();
        bit strobe, ackc;
        strobe = (t == tx_t + 1);
        ackc   = (t == tx_t + 2);
        mack0  = ackc && tx_owner == 0;
        mack1  = ackc && tx_owner == 1;
        chk("s_wen", s_wen, strobe && tx_wen);
        chk("s_ren", s_ren, strobe && !tx_wen);
        chk("s_addr", s_addr, tx_addr);
        chk("s_wrdata", s_wdata, tx_wdata);
        chk("m0_ack", m0_ack, mack0);
        chk("m1_ack", m1_ack, mack1);
        chk("m0_rddata", m0_rd, exp_rd[0]);
        chk("m1_rddata", m1_rd, exp_rd[1]);
        chk("busy", busy, strobe || ackc);
        chk("ack_excl", m0_ack & m1_ack, 0);
        if (m0_ack) begin ack_cyc.push_back(t); ack_who.push_back(0); end
        if (m1_ack) begin ack_cyc.push_back(t); ack_who.push_back(1); end
    endtask

    task automatic model_step();
        if (t == tx_t + 1) exp_rd[tx_owner] = tx_wen ? 32'h0 : srd(tx_addr);
        else if (t > tx_t + 2 && (m0_req || m1_req)) begin
            tx_owner = (m1_req && (!m0_req || last == 0)) ? 1 : 0;
            last     = tx_owner;
            tx_t     = t;
            tx_wen   = tx_owner ? m1_wen : m0_wen;
            tx_addr  = tx_owner ? m1_addr : m0_addr;
            tx_wdata = tx_owner ? m1_wdata : m0_wdata;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        model_step();
        @(posedge clk);
        #1 t++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out"}, {s_wen, s_ren, m0_ack, m1_ack, busy}, 0);
        chk({tag, "_addr"}, s_addr | s_wdata, 0);
        chk({tag, "_rd"}, m0_rd | m1_rd, 0);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 chk_zero("rst");
        model_reset();
        m0_req = 0; m1_req = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        t++;
    endtask

    task automatic xfer(input bit m, input bit wen, input logic [31:0] a, input logic [31:0] d);
        bit done = 0;
        if (m) begin m1_req = 1; m1_wen = wen; m1_addr = a; m1_wdata = d; end
        else   begin m0_req = 1; m0_wen = wen; m0_addr = a; m0_wdata = d; end
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            done = m ? mack1 : mack0;
        end
        if (!done) chk("xfer_timeout", 0, 1);
        if (m) m1_req = 0; else m0_req = 0;
    endtask

    function automatic logic [31:0] raddr();
        return 32'h2000_0000 | ($urandom_range(0, 16383) << 2);
    endfunction

    initial begin
        int tb, base;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_zero("por");
        rst_n = 1'b1;
        // 1: m0 read, strobe at T+1 and ack at T+2 checked cycle by cycle
        tb = t;
        xfer(0, 0, 32'h2000_BFF8, 0);
        chk("t1_rd", m0_rd, 32'h0000_0123);
        chk("t1_ack_cyc", ack_cyc[$], tb + 2);
        // 2: m1 write
        tb = t;
        xfer(1, 1, 32'h2000_4000, 32'h0000_0064);
        chk("t2_rd", m1_rd, 0);
        chk("t2_ack_cyc", ack_cyc[$], tb + 2);
        // 3: simultaneous first requests after reset, m0 wins the tie
        tick();
        async_reset();
        m0_req = 1; m0_wen = 0; m0_addr = 32'h2000_0010;
        m1_req = 1; m1_wen = 0; m1_addr = 32'h2000_0020;
        tb = t; base = ack_who.size();
        for (int i = 0; i < 20 && (m0_req || m1_req); i++) begin
            tick();
            if (mack0) m0_req = 0;
            if (mack1) m1_req = 0;
        end
        chk("t3_nacks", ack_who.size() - base, 2);
        if (ack_who.size() - base == 2) begin
            chk("t3_first", ack_who[base], 0);
            chk("t3_first_cyc", ack_cyc[base], tb + 2);
            chk("t3_second", ack_who[base+1], 1);
            chk("t3_second_cyc", ack_cyc[base+1], tb + 5);
        end
        // 4: continuous requests alternate at 3-cycle spacing
        m0_req = 1; m1_req = 1; base = ack_who.size();
        for (int i = 0; i < 18; i++) begin
            tick();
            if (mack0) begin m0_addr = raddr(); m0_wen = $urandom_range(0, 1); m0_wdata = $urandom; end
            if (mack1) begin m1_addr = raddr(); m1_wen = $urandom_range(0, 1); m1_wdata = $urandom; end
        end
        chk("t4_nacks", ack_who.size() - base, 6);
        if (ack_who.size() - base >= 6)
            for (int i = 0; i < 6; i++) begin
                chk("t4_order", ack_who[base+i], i % 2);
                chk("t4_spacing", ack_cyc[base+i] - ack_cyc[base], 3 * i);
            end
        m0_req = 0; m1_req = 0;
        repeat (3) tick();
        // 5: reset during ACCESS of an m0 write drops the transaction
        m0_req = 1; m0_wen = 1; m0_addr = 32'h2000_4008; m0_wdata = 32'hDEAD_BEEF;
        tick();
        chk("t5_in_access", s_wen, 1);
        async_reset();
        base = ack_who.size();
        repeat (10) tick();
        chk("t5_no_ack", ack_who.size() - base, 0);
        chk("t5_busy", busy, 0);
        // 6: address change after grant does not reach the slave
        m0_req = 1; m0_wen = 0; m0_addr = 32'h2000_4000;
        tick();
        m0_addr = 32'h2000_4004;
        chk("t6_s_addr", s_addr, 32'h2000_4000);
        tick();
        tick();
        chk("t6_acked", mack0, 1);
        m0_req = 0;
        tick();
        // random traffic with masters obeying the hold-until-ack rule
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!m0_req || mack0) begin
                m0_req = ($urandom_range(0, 3) != 0); m0_wen = $urandom_range(0, 1);
                m0_addr = raddr(); m0_wdata = $urandom;
            end
            if (!m1_req || mack1) begin
                m1_req = ($urandom_range(0, 3) != 0); m1_wen = $urandom_range(0, 1);
                m1_addr = raddr(); m1_wdata = $urandom;
            end
        end
        m0_req = 0; m1_req = 0;
        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/clint_bus_arbiter.md
Name: clint_bus_arbiter

Overview:
- Two-master, one-slave arbiter that shares the CLINT register port between the hart data port (m0) and a secondary master (m1, debug/DMA).
- Serializes accesses with a req/ack handshake and round-robin fairness.
- Latches request fields, drives exactly one slave access strobe per transaction, and registers the read data back to the winner.
- Sits between the core's memory interconnect and the CLINT slave port.

Parameters:
DATA_W, 32, width of address, write data and read data (matches `XLEN)
RR_RESET_LAST, 1, initial "last granted" master after reset; 1 means m0 wins the first tie

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
i_m0_req  in  1  m0 request; held stable with wen/addr/wrdata until o_m0_ack
i_m0_wen  in  1  m0 write(1)/read(0)
i_m0_addr  in  DATA_W  m0 address
i_m0_wrdata  in  DATA_W  m0 write data
o_m0_ack  out  1  one-cycle completion pulse to m0
o_m0_rddata  out  DATA_W  m0 read data, valid while o_m0_ack=1
i_m1_req, i_m1_wen, i_m1_addr, i_m1_wrdata, o_m1_ack, o_m1_rddata  same as m0, for m1
o_s_wen  out  1  slave write strobe
o_s_ren  out  1  slave read strobe
o_s_addr  out  DATA_W  slave address
o_s_wrdata  out  DATA_W  slave write data
i_s_rddata  in  DATA_W  slave read data, combinational from o_s_addr/o_s_ren
o_busy  out  1  1 whenever the FSM is not IDLE

Behaviour:
- Reset (i_rst=0, asynchronous):
  - All outputs 0; state=IDLE; latched addr/wrdata/wen/owner cleared; last_grant=RR_RESET_LAST.
  - An in-flight transaction is dropped: no ack and no further slave strobe after reset release.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that master.
  - Both req: grant the master that is NOT last_grant.
  - On grant: latch owner, wen, addr and wrdata from the winner; go to ACCESS next edge.
- ACCESS (exactly 1 cycle):
  - o_s_addr/o_s_wrdata driven from the latched values.
  - o_s_wen=latched wen; o_s_ren=!latched wen.
  - Owner's rddata register loads i_s_rddata on a read, 0 on a write.
  - last_grant<=owner. Go to RESP.
- RESP (exactly 1 cycle):
  - Owner's ack=1; other master's ack=0.
  - Slave strobes 0; o_s_addr/o_s_wrdata hold their last values. Go to IDLE.
- Outside ACCESS: o_s_wen=o_s_ren=0.
- o_mX_rddata is registered and holds its value until that master's next transaction completes.
- Latency: req sampled in IDLE at cycle T → slave strobe at T+1 → ack at T+2. Throughput is 1 transaction per 3 cycles.
- Handshake rules:
  - A master must hold its request fields stable until it sees ack.
  - A req still high in the cycle after ack is treated as a new request.
  - Because fields are latched at grant, changes after grant do not affect the in-flight access.
- Req deasserted before ack (protocol violation): the access still completes and ack is still pulsed.
- Continuous requests from both masters strictly alternate: m0, m1, m0, … when RR_RESET_LAST=1.
- A new req arriving during ACCESS/RESP waits; it is evaluated only in IDLE.
- Exactly one of o_s_wen/o_s_ren is high per transaction, for exactly one cycle.
- o_m0_ack and o_m1_ack are never both 1.

Test Plan:
1. Reset release, m0 read of addr 0x2000_BFF8, slave returns 0x0000_0123 → o_s_ren=1 for one cycle at T+1 with o_s_addr=0x2000_BFF8; o_m0_ack=1 at T+2 with o_m0_rddata=0x0000_0123; o_m1_ack stays 0.
2. m1 write of 0x0000_0064 to 0x2000_4000 → o_s_wen=1 for one cycle with that addr/data; o_s_ren stays 0; o_m1_ack at T+2; o_m1_rddata=0.
3. m0 and m1 both request first at the same cycle after reset (RR_RESET_LAST=1) → m0 served first (ack at T+2), m1 served second (ack at T+5).
4. Both hold req continuously for 6 transactions → ack order m0,m1,m0,m1,m0,m1 at 3-cycle spacing; never two acks in one cycle.
5. Assert i_rst=0 during ACCESS of an m0 write → outputs 0 immediately (asynchronously); after release with no req, no ack and no strobe within 10 cycles; o_busy=0.
6. m0 changes addr from 0x2000_4000 to 0x2000_4004 during ACCESS → slave sees 0x2000_4000 only; ack is still issued.
